// File: rtl/jtag_axi_txn_ctrl.sv
// JTAG-to-AXI transaction sequencer: runs one single-beat AXI4 read or write per
// JTAG command and reports the response, read data or timeout to the status DR.
module jtag_axi_txn_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    tck,
  input  logic                    trstn,
  input  logic                    cmd_start,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_size,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic [2:0]              sts_resp,
  output logic [DATA_WIDTH-1:0]   sts_rdata,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awsize,
  output logic [7:0]              awlen,
  output logic [1:0]              awburst,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arsize,
  output logic [7:0]              arlen,
  output logic [1:0]              arburst,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAX_SIZE   = $clog2(STRB_WIDTH);
  localparam int TW         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] RESP_TIMEOUT  = 3'd4;
  localparam logic [2:0] RESP_REJECTED = 3'd5;
  localparam logic [2:0] RESP_PENDING  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP, ST_ABORT
  } state_e;

  state_e                  state_q, state_d;
  logic                    is_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [2:0]              size_q;
  logic                    aw_done_q, w_done_q, ar_done_q;
  logic [TW-1:0]           timer_q;
  logic                    reject_q;
  logic                    sts_done_q;
  logic [2:0]              sts_resp_q;
  logic [DATA_WIDTH-1:0]   sts_rdata_q;

  logic aw_hs, w_hs, ar_hs, in_txn, completion, timeout_hit;
  logic size_ok, accept, bad_size, busy_drop;
  logic unused_rlast;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign ar_hs       = arvalid & arready;
  assign in_txn      = state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP};
  assign completion  = (state_q == ST_WR_RESP && bvalid) || (state_q == ST_RD_RESP && rvalid);
  // A real response arriving in the timeout cycle takes priority over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_txn && (timer_q == TIMER_LAST) && !completion;
  assign size_ok     = cmd_size <= 3'(MAX_SIZE);
  assign accept      = (state_q == ST_IDLE) && cmd_start && size_ok;
  assign bad_size    = (state_q == ST_IDLE) && cmd_start && !size_ok;
  assign busy_drop   = (state_q != ST_IDLE) && cmd_start;
  assign unused_rlast = rlast;

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = cmd_wr ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ: begin
        if (timeout_hit) state_d = ST_ABORT;
        else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bvalid)           state_d = ST_IDLE;
        else if (timeout_hit) state_d = ST_ABORT;
      end
      ST_RD_REQ: begin
        if (timeout_hit) state_d = ST_ABORT;
        else if (ar_hs)  state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (rvalid)           state_d = ST_IDLE;
        else if (timeout_hit) state_d = ST_ABORT;
      end
      // Drain the abandoned transaction; the slave may only respond once its requests are taken.
      ST_ABORT:   if (is_wr_q ? bvalid : rvalid) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    unique case (state_q)
      ST_WR_REQ: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      ST_WR_RESP: bready = 1'b1;
      ST_RD_REQ:  arvalid = 1'b1;
      ST_RD_RESP: rready = 1'b1;
      ST_ABORT: begin
        awvalid = is_wr_q && !aw_done_q;
        wvalid  = is_wr_q && !w_done_q;
        bready  = is_wr_q;
        arvalid = !is_wr_q && !ar_done_q;
        rready  = !is_wr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      size_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ar_done_q   <= 1'b0;
      timer_q     <= '0;
      reject_q    <= 1'b0;
      sts_done_q  <= 1'b0;
      sts_resp_q  <= '0;
      sts_rdata_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      sts_done_q <= 1'b0;
      if (accept) begin
        is_wr_q    <= cmd_wr;
        addr_q     <= cmd_addr;
        wdata_q    <= cmd_wdata;
        wstrb_q    <= cmd_wstrb;
        size_q     <= cmd_size;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        ar_done_q  <= 1'b0;
        timer_q    <= '0;
        reject_q   <= 1'b0;
        sts_resp_q <= RESP_PENDING;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
        if (ar_hs) ar_done_q <= 1'b1;
        if (in_txn && timer_q != '1) timer_q <= timer_q + 1'b1;
        if (busy_drop) reject_q <= 1'b1;
        if (bad_size) begin
          sts_resp_q <= RESP_REJECTED;
          sts_done_q <= 1'b1;
        end
        if (completion) begin
          if (state_q == ST_RD_RESP) sts_rdata_q <= rdata;
          sts_resp_q <= (reject_q || busy_drop) ? RESP_REJECTED
                      : {1'b0, (state_q == ST_WR_RESP) ? bresp : rresp};
          sts_done_q <= 1'b1;
        end else if (timeout_hit) begin
          sts_resp_q <= RESP_TIMEOUT;
          sts_done_q <= 1'b1;
        end
      end
    end
  end

  assign sts_busy  = (state_q != ST_IDLE);
  assign sts_done  = sts_done_q;
  assign sts_resp  = sts_resp_q;
  assign sts_rdata = sts_rdata_q;

  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awprot  = 3'b000;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Directed bench for jtag_axi_txn_ctrl against a small configurable AXI slave.
// Latency is counted in clock edges after the edge that samples cmd_start.
module tb_jtag_axi_txn_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BUDGET = 40;

  logic          tck = 1'b0;
  logic          trstn;
  logic          cmd_start, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic [2:0]    cmd_size;
  logic          sts_busy, sts_done;
  logic [2:0]    sts_resp;
  logic [DW-1:0] sts_rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, wlast, rlast;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [7:0]    awlen, arlen;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;

  // Slave configuration and observations
  int            aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit            b_hold = 0, r_hold = 0;
  logic [1:0]    bresp_cfg = 2'd0, rresp_cfg = 2'd0;
  logic [DW-1:0] rdata_cfg = '0;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [DW-1:0] cap_wdata;
  logic [3:0]    cap_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tck = ~tck;

  jtag_axi_txn_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .tck(tck), .trstn(trstn),
    .cmd_start(cmd_start), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb), .cmd_size(cmd_size),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_resp(sts_resp), .sts_rdata(sts_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize), .awlen(awlen),
    .awburst(awburst), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize), .arlen(arlen),
    .arburst(arburst), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: samples handshakes on the edge, drives its inputs 1 ns later.
  initial begin : slave
    int  aw_wait, w_wait, ar_wait;
    bit  aw_seen, w_seen, b_pend, r_pend;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = '0; rlast = 1'b1;
    forever begin
      @(posedge tck);
      if (!trstn) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
      end else begin
        if (awvalid && awready) begin
          aw_seen = 1; aw_cnt++; cap_awaddr = awaddr; aw_wait = 0;
        end else if (awvalid) aw_wait++;
        if (wvalid && wready) begin
          w_seen = 1; w_cnt++; cap_wdata = wdata; cap_wstrb = wstrb; w_wait = 0;
        end else if (wvalid) w_wait++;
        if (bvalid && bready) begin b_cnt++; b_pend = 0; end
        if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
        if (rvalid && rready) r_pend = 0;
        if (arvalid && arready) begin
          ar_cnt++; cap_araddr = araddr; r_pend = 1; ar_wait = 0;
        end else if (arvalid) ar_wait++;
      end
      #1;
      awready = (aw_wait >= aw_delay);
      wready  = (w_wait >= w_delay);
      arready = (ar_wait >= ar_delay);
      bvalid  = b_pend && !b_hold;
      rvalid  = r_pend && !r_hold;
      bresp   = bresp_cfg;
      rresp   = rresp_cfg;
      rdata   = rdata_cfg;
    end
  end

  // Presents a command for one edge, then scrambles the inputs to prove they were registered.
  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input logic [2:0] size);
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_size = size;
    cmd_start = 1'b1;
    @(posedge tck); #1;
    cmd_start = 1'b0; cmd_wr = ~wr; cmd_addr = ~addr; cmd_wdata = ~data; cmd_wstrb = ~strb;
    cmd_size = 3'd0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = -1;
    for (int i = base; i <= base + BUDGET; i++) begin
      if (i > base) begin @(posedge tck); #1; end
      if (sts_done) begin lat = i; break; end
    end
  endtask

  initial begin : main
    int lat, aw0, b0, ar0, dones, idle_at;
    bit got;
    trstn = 1'b0; cmd_start = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_size = '0;
    repeat (3) @(posedge tck);
    #1;
    check("rst_busy", sts_busy, 0);
    check("rst_done", sts_done, 0);
    check("rst_resp", sts_resp, 0);
    check("rst_rdata", sts_rdata, 0);
    check("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    check("rst_readys", {bready, rready}, 2'b00);
    trstn = 1'b1;
    @(posedge tck); #1;

    // Write with an always-ready slave
    start_cmd(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 3'd2);
    check("wr_busy", sts_busy, 1);
    check("wr_pending", sts_resp, 7);
    check("wr_aw_w_together", {awvalid, wvalid}, 2'b11);
    check("wr_attrs", {awlen, awburst, awprot, wlast}, {8'd0, 2'b01, 3'b000, 1'b1});
    wait_done(0, lat);
    check("wr_latency", lat, 2);
    check("wr_resp", sts_resp, 0);
    check("wr_bus_addr", cap_awaddr, 32'h1000);
    check("wr_bus_data", {cap_wdata, cap_wstrb}, {32'hCAFE_F00D, 4'hF});
    check("wr_counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, 24'h010101);
    @(posedge tck); #1;
    check("wr_done_pulse", {sts_done, sts_busy}, 2'b00);

    // Read, arready after 5 cycles, SLVERR
    ar_delay = 5; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'd2;
    start_cmd(1'b0, 32'h2000, 32'h0, 4'h0, 3'd2);
    wait_done(0, lat);
    check("rd_latency", lat, 7);
    check("rd_rdata", sts_rdata, 32'h1234_5678);
    check("rd_resp", sts_resp, 2);
    check("rd_bus_addr", cap_araddr, 32'h2000);
    check("rd_ar_count", ar_cnt, 1);

    // Write with W accepted 4 cycles after AW, DECERR
    ar_delay = 0; w_delay = 4; bresp_cfg = 2'd3;
    aw0 = aw_cnt; b0 = b_cnt;
    start_cmd(1'b1, 32'h3000, 32'h0BAD_F00D, 4'h3, 3'd1);
    @(posedge tck); #1;
    check("split_aw_dropped", {awvalid, wvalid}, 2'b01);
    wait_done(1, lat);
    check("split_latency", lat, 6);
    check("split_resp", sts_resp, 3);
    check("split_wdata", {cap_wdata, cap_wstrb}, {32'h0BAD_F00D, 4'h3});
    repeat (3) @(posedge tck);
    #1;
    check("split_one_aw", aw_cnt - aw0, 1);
    check("split_one_b", b_cnt - b0, 1);

    // Second command while a read is in flight
    w_delay = 0; bresp_cfg = 2'd0; ar_delay = 2; rdata_cfg = 32'hA5A5_5A5A; rresp_cfg = 2'd0;
    aw0 = aw_cnt; ar0 = ar_cnt;
    start_cmd(1'b0, 32'h4000, 32'h0, 4'h0, 3'd2);
    cmd_wr = 1'b1; cmd_addr = 32'h5000; cmd_start = 1'b1;
    @(posedge tck); #1;
    cmd_start = 1'b0;
    wait_done(1, lat);
    check("rej_latency", lat, 4);
    check("rej_resp", sts_resp, 5);
    check("rej_rdata", sts_rdata, 32'hA5A5_5A5A);
    repeat (4) @(posedge tck);
    #1;
    check("rej_single_ar", ar_cnt - ar0, 1);
    check("rej_no_aw", aw_cnt - aw0, 0);
    check("rej_idle", sts_busy, 0);

    // Next accepted command clears the rejection
    ar_delay = 0; bresp_cfg = 2'd1;
    start_cmd(1'b1, 32'h5004, 32'h1111_2222, 4'hF, 3'd2);
    wait_done(0, lat);
    check("clr_latency", lat, 2);
    check("clr_resp", sts_resp, 1);

    // Unsupported size is rejected without a bus transaction
    ar0 = ar_cnt;
    start_cmd(1'b0, 32'h6000, 32'h0, 4'h0, 3'd3);
    check("size_done", {sts_done, sts_busy}, 2'b10);
    check("size_resp", sts_resp, 5);
    check("size_no_ar", arvalid, 0);
    @(posedge tck); #1;
    check("size_pulse_end", sts_done, 0);
    check("size_no_bus", ar_cnt - ar0, 0);

    // Write timeout: B withheld, then drained in ABORT
    bresp_cfg = 2'd0; b_hold = 1; b0 = b_cnt;
    start_cmd(1'b1, 32'h7000, 32'hDEAD_0001, 4'hF, 3'd2);
    wait_done(0, lat);
    check("to_latency", lat, 16);
    check("to_resp", sts_resp, 4);
    check("to_abort_hold", {sts_busy, bready}, 2'b11);
    dones = 0;
    repeat (3) begin @(posedge tck); #1; if (sts_done) dones++; end
    b_hold = 0;
    idle_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge tck); #1;
      if (sts_done) dones++;
      if (!sts_busy) begin idle_at = i; break; end
    end
    check("to_drained", idle_at >= 0, 1);
    check("to_no_done", dones, 0);
    check("to_resp_kept", sts_resp, 4);
    check("to_one_b", b_cnt - b0, 1);

    // Reset in RD_RESP, then a fresh read
    r_hold = 1;
    start_cmd(1'b0, 32'h8000, 32'h0, 4'h0, 3'd2);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (rready) begin got = 1; break; end
      @(posedge tck); #1;
    end
    check("rst_mid_reached", got, 1);
    #2 trstn = 1'b0;
    #1;
    check("rst_mid_bus", {arvalid, rready}, 2'b00);
    check("rst_mid_sts", {sts_busy, sts_done, sts_resp}, 5'b0);
    @(posedge tck);
    @(posedge tck); #1;
    trstn = 1'b1; r_hold = 0; rdata_cfg = 32'h0F0F_1234; rresp_cfg = 2'd0;
    @(posedge tck); #1;
    start_cmd(1'b0, 32'h8004, 32'h0, 4'h0, 3'd2);
    wait_done(0, lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_resp", sts_resp, 0);
    check("post_rst_rdata", sts_rdata, 32'h0F0F_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
